clause_ctrl: RTL and testbench
==============================

Name: clause_ctrl

Overview:
- Per-clause controller sitting directly downstream of a chain of NUM_LITS literal cells.
- It writes the clause's literal codes into the cells.
- It consumes the cells' end-of-chain free-literal count, the per-cell satisfied flags and the per-cell conflict flags.
- Per evaluation it classifies the clause as unresolved, satisfied, unit or conflicting. It drives the cells' implication-drive and conflict-drive inputs with cycle-exact timing.

Parameters:
NUM_LITS, 8, number of literal cells in the clause (>=2)
IDX_W, 3, width of the load index; must satisfy 2**IDX_W >= NUM_LITS

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
load_valid_i  in  1  literal load beat valid
load_ready_o  out  1  load beat accepted when valid&ready
load_lit_i  in  2  literal code: 01 = positive, 10 = negative, 00 = absent
load_last_i  in  1  final beat of the clause
wr_o  out  NUM_LITS  per-cell write strobe
lit_o  out  2*NUM_LITS  per-cell literal code; cell k uses bits [2k+1:2k]
eval_start_i  in  1  start one clause evaluation (pulse)
freelitcnt_i  in  2  end of the cell free-count chain: 00 none, 01 one, 11 two or more
clausesat_i  in  NUM_LITS  per-cell satisfied flag
cclause_i  in  NUM_LITS  per-cell conflict flag
imp_drv_o  out  1  implication drive to all cells
cclause_drv_o  out  1  conflict drive to all cells
conflict_ack_i  in  1  downstream acknowledges conflict
done_o  out  1  one-cycle result strobe
result_o  out  2  00 unresolved, 01 satisfied, 10 implied, 11 conflict; valid with done_o, held until the next done_o
ovf_o  out  1  sticky: more than NUM_LITS beats were received in one load

Behaviour:
- Reset (rst=0, any time, asynchronous):
  - state=IDLE, index=0.
  - All outputs 0, including result_o and ovf_o; load_ready_o=0 during reset.
  - Any operation in progress (load or evaluation) is abandoned.
- States: IDLE, LOAD, EVAL, IMPLY, CHECK, CDRV.
- load_ready_o=1 in IDLE and LOAD only.

Load:
- An accepted beat writes load_lit_i into cell[index]: wr_o[index]=1 and lit_o slice = load_lit_i in that same cycle. Then index increments.
- On a beat with load_last_i=1, all cells above index are written with 00 in that same cycle, clearing stale literals. index returns to 0 and state goes to IDLE.
- The first accepted beat in IDLE moves the state to LOAD, unless that beat also has last=1.
- Beats after index reaches NUM_LITS: accepted, no write, ovf_o set sticky. The last beat still terminates the load.
- ovf_o clears only on reset or on the first beat of a new load.
- wr_o=0 whenever no beat is accepted.

Evaluation:
- eval_start_i is honoured only in IDLE. If load_valid_i is also high in that cycle, the load wins and the start is dropped.
- A start at cycle t moves to EVAL; decision is at t+1 with sat = OR(clausesat_i):
  - sat: done_o at t+1, result 01, go to IDLE.
  - freelitcnt_i=11: done_o at t+1, result 00, go to IDLE.
  - freelitcnt_i=00: done_o at t+1, result 11, go to CDRV.
  - freelitcnt_i=01: go to IMPLY.
- IMPLY (t+2): imp_drv_o=1 for exactly this cycle, then go to CHECK.
- CHECK (t+3):
  - Any cclause_i set: done_o, result 11, go to CDRV.
  - Otherwise: done_o, result 10, go to IDLE.
- CDRV: cclause_drv_o=1 continuously. conflict_ack_i is sampled only in CDRV. When it is sampled high, cclause_drv_o drops in the next cycle and the state goes to IDLE.
- An empty clause (all cells 00) evaluates as conflict.
- eval_start_i and load beats outside the states above are ignored; load_ready_o=0.

Test Plan:
- Load beats 01,10,01(last) into a cell array previously holding 8 literals -> wr_o one-hot at indices 0,1,2, then the final cycle asserts wr_o[7:2] with lit 00 for cells 3..7; ovf_o=0.
- clausesat_i=0x04 at EVAL -> done_o at t+1, result_o=01, imp_drv_o never asserted.
- freelitcnt_i=01, no sat, cclause_i=0 -> imp_drv_o high at t+2 only, done_o at t+3, result_o=10.
- freelitcnt_i=01 and cclause_i=0x01 at t+3 -> result_o=11, cclause_drv_o high until conflict_ack_i is sampled, then low next cycle, state IDLE.
- Nine beats with NUM_LITS=8 -> ninth beat accepted with no write, ovf_o=1; next load's first beat clears it. Also: eval_start_i together with load_valid_i in IDLE -> load proceeds, no done_o.
- Assert rst=0 mid-CDRV and mid-LOAD -> all outputs 0 immediately; after release, a fresh load works and index starts at 0.

Source files
------------

// File: rtl/clause_ctrl.sv
// Per-clause controller: loads literal codes into a chain of literal cells and
// classifies the clause (unresolved / satisfied / unit / conflict) on request.
module clause_ctrl #(
    parameter int NUM_LITS = 8,
    parameter int IDX_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid_i,
    output logic                  load_ready_o,
    input  logic [1:0]            load_lit_i,
    input  logic                  load_last_i,
    output logic [NUM_LITS-1:0]   wr_o,
    output logic [2*NUM_LITS-1:0] lit_o,
    input  logic                  eval_start_i,
    input  logic [1:0]            freelitcnt_i,
    input  logic [NUM_LITS-1:0]   clausesat_i,
    input  logic [NUM_LITS-1:0]   cclause_i,
    output logic                  imp_drv_o,
    output logic                  cclause_drv_o,
    input  logic                  conflict_ack_i,
    output logic                  done_o,
    output logic [1:0]            result_o,
    output logic                  ovf_o,
    output logic [2:0]            state_o
);

    // Load handshake: a beat transfers in any cycle where load_valid_i and
    // load_ready_o are both high; ready is high only in IDLE and LOAD.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EVAL  = 3'd2,
        IMPLY = 3'd3,
        CHECK = 3'd4,
        CDRV  = 3'd5
    } state_e;

    localparam int         CNT_W     = IDX_W + 1;
    localparam logic [1:0] RES_UNRES = 2'b00;
    localparam logic [1:0] RES_SAT   = 2'b01;
    localparam logic [1:0] RES_IMP   = 2'b10;
    localparam logic [1:0] RES_CONF  = 2'b11;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [1:0]       result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             beat;
    logic             in_range;

    // Ready is forced low while reset is asserted, not just after it.
    assign load_ready_o = rst & ((state_q == IDLE) | (state_q == LOAD));
    assign beat         = load_valid_i & load_ready_o;
    assign in_range     = (idx_q < CNT_W'(NUM_LITS));

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        ovf_d         = ovf_q;
        result_d      = result_q;
        wr_o          = '0;
        lit_o         = '0;
        done_o        = 1'b0;
        imp_drv_o     = (state_q == IMPLY);
        cclause_drv_o = (state_q == CDRV);
        unique case (state_q)
            IDLE, LOAD: begin
                if (beat) begin
                    if (state_q == IDLE) ovf_d = 1'b0;
                    if (in_range) begin
                        for (int k = 0; k < NUM_LITS; k++) begin
                            if (CNT_W'(k) == idx_q) begin
                                wr_o[k]        = 1'b1;
                                lit_o[2*k +: 2] = load_lit_i;
                            end
                        end
                        idx_d = idx_q + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (load_last_i) begin
                        // Clear stale literals above the final beat (lit stays 00).
                        for (int k = 0; k < NUM_LITS; k++) begin
                            if (CNT_W'(k) > idx_q) wr_o[k] = 1'b1;
                        end
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end else if ((state_q == IDLE) && eval_start_i) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (|clausesat_i) begin
                    done_o   = 1'b1;
                    result_d = RES_SAT;
                    state_d  = IDLE;
                end else if (freelitcnt_i == 2'b01) begin
                    state_d = IMPLY;
                end else if (freelitcnt_i == 2'b00) begin
                    done_o   = 1'b1;
                    result_d = RES_CONF;
                    state_d  = CDRV;
                end else begin
                    done_o   = 1'b1;
                    result_d = RES_UNRES;
                    state_d  = IDLE;
                end
            end
            IMPLY: state_d = CHECK;
            CHECK: begin
                done_o = 1'b1;
                if (|cclause_i) begin
                    result_d = RES_CONF;
                    state_d  = CDRV;
                end else begin
                    result_d = RES_IMP;
                    state_d  = IDLE;
                end
            end
            CDRV: if (conflict_ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // result_d equals result_q except on a done cycle, so the strobe cycle
    // already shows the new result and it is held afterwards.
    assign result_o = result_d;
    assign ovf_o    = ovf_q;
    assign state_o  = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            result_q <= RES_UNRES;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_clause_ctrl.sv
// Directed bench for clause_ctrl: load sequences, every evaluation outcome,
// overflow, load/start collision and asynchronous reset mid-operation.
module tb_clause_ctrl;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [1:0]  load_lit;
    logic        load_last;
    logic [7:0]  wr;
    logic [15:0] lit;
    logic        eval_start;
    logic [1:0]  freelit;
    logic [7:0]  clausesat;
    logic [7:0]  cclause;
    logic        imp_drv;
    logic        cclause_drv;
    logic        conflict_ack;
    logic        done;
    logic [1:0]  result;
    logic        ovf;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    clause_ctrl #(.NUM_LITS(8), .IDX_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .load_valid_i   (load_valid),
        .load_ready_o   (load_ready),
        .load_lit_i     (load_lit),
        .load_last_i    (load_last),
        .wr_o           (wr),
        .lit_o          (lit),
        .eval_start_i   (eval_start),
        .freelitcnt_i   (freelit),
        .clausesat_i    (clausesat),
        .cclause_i      (cclause),
        .imp_drv_o      (imp_drv),
        .cclause_drv_o  (cclause_drv),
        .conflict_ack_i (conflict_ack),
        .done_o         (done),
        .result_o       (result),
        .ovf_o          (ovf),
        .state_o        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lit_mask(input logic [7:0] w);
        logic [15:0] m;
        m = '0;
        for (int k = 0; k < 8; k++) if (w[k]) m[2*k +: 2] = 2'b11;
        return m;
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic load_beat(input logic [1:0] l, input logic last, input logic [7:0] exp_wr,
                             input logic [15:0] exp_lit, input string tag);
        load_valid = 1'b1;
        load_lit   = l;
        load_last  = last;
        #1;
        check({tag, "_ready"}, 32'(load_ready), 32'(1));
        check({tag, "_wr"}, 32'(wr), 32'(exp_wr));
        check({tag, "_lit"}, 32'(lit & lit_mask(exp_wr)), 32'(exp_lit));
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_lit   = 2'b00;
    endtask

    task automatic do_eval(input logic [7:0] sat, input logic [1:0] fc, input logic [7:0] cc,
                           input logic [1:0] exp_res, input int exp_lat, input string tag);
        int imp_at;
        int imp_cnt;
        int done_at;
        logic [1:0] got;
        logic [1:0] exp_pop;
        exp_q.push_back(exp_res);
        imp_at  = -1;
        imp_cnt = 0;
        done_at = -1;
        got     = 2'b00;
        eval_start = 1'b1;
        #1;
        check({tag, "_start_nodone"}, 32'(done), 32'(0));
        @(negedge clk);
        eval_start = 1'b0;
        clausesat  = sat;
        freelit    = fc;
        cclause    = cc;
        for (int c = 1; c <= 5 && done_at < 0; c++) begin
            #1;
            if (imp_drv) begin
                imp_cnt++;
                imp_at = c;
            end
            if (done) begin
                done_at = c;
                got     = result;
            end
            @(negedge clk);
        end
        exp_pop = exp_q.pop_front();
        check({tag, "_latency"}, 32'(done_at), 32'(exp_lat));
        check({tag, "_result"}, 32'(got), 32'(exp_pop));
        check({tag, "_imp_cnt"}, 32'(imp_cnt), 32'((exp_lat == 3) ? 1 : 0));
        check({tag, "_imp_at"}, 32'(imp_at), 32'((exp_lat == 3) ? 2 : -1));
        clausesat = '0;
        freelit   = 2'b00;
        cclause   = '0;
        #1;
        check({tag, "_held"}, 32'(result), 32'(exp_pop));
        check({tag, "_done_pulse"}, 32'(done), 32'(0));
        check({tag, "_cdrv"}, 32'(cclause_drv), 32'((exp_pop == 2'b11) ? 1 : 0));
        @(negedge clk);
    endtask

    task automatic ack_conflict(input string tag);
        #1;
        check({tag, "_cdrv_hold"}, 32'(cclause_drv), 32'(1));
        conflict_ack = 1'b1;
        @(negedge clk);
        conflict_ack = 1'b0;
        #1;
        check({tag, "_cdrv_drop"}, 32'(cclause_drv), 32'(0));
        check({tag, "_idle"}, 32'(state), 32'(0));
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  ew;
        logic [15:0] el;
        logic [1:0]  l;
        int          dcnt;

        rst = 1'b0; load_valid = 1'b0; load_lit = 2'b00; load_last = 1'b0;
        eval_start = 1'b0; freelit = 2'b00; clausesat = '0; cclause = '0; conflict_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 32'(load_ready), 32'(0));
        check("rst_wr", 32'(wr), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_result", 32'(result), 32'(0));
        check("rst_ovf", 32'(ovf), 32'(0));
        check("rst_state", 32'(state), 32'(0));
        check("rst_drv", 32'({imp_drv, cclause_drv}), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Fill all eight cells.
        for (int i = 0; i < 8; i++) begin
            l  = (i % 2 == 1) ? 2'b10 : 2'b01;
            ew = 8'(1 << i);
            el = 16'(l) << (2 * i);
            load_beat(l, (i == 7), ew, el, "fill");
        end
        // Shorter clause overwrites; final beat clears cells 3..7.
        load_beat(2'b01, 1'b0, 8'h01, 16'h0001, "short0");
        load_beat(2'b10, 1'b0, 8'h02, 16'h0008, "short1");
        load_beat(2'b01, 1'b1, 8'hFC, 16'h0010, "short2");
        #1;
        check("short_ovf", 32'(ovf), 32'(0));
        check("short_idle", 32'(state), 32'(0));
        @(negedge clk);

        do_eval(8'h04, 2'b01, 8'h00, 2'b01, 1, "sat");
        do_eval(8'h00, 2'b01, 8'h00, 2'b10, 3, "imply");
        do_eval(8'h00, 2'b11, 8'h00, 2'b00, 1, "unres");
        do_eval(8'h00, 2'b01, 8'h01, 2'b11, 3, "imp_conf");
        ack_conflict("imp_conf");
        do_eval(8'h00, 2'b00, 8'h00, 2'b11, 1, "empty");
        ack_conflict("empty");

        // Nine beats: the ninth is accepted without a write and sets ovf.
        for (int i = 0; i < 9; i++) begin
            l  = (i % 2 == 1) ? 2'b01 : 2'b10;
            ew = (i < 8) ? 8'(1 << i) : 8'h00;
            el = (i < 8) ? (16'(l) << (2 * i)) : 16'h0000;
            load_beat(l, (i == 8), ew, el, "ovf");
        end
        #1;
        check("ovf_set", 32'(ovf), 32'(1));
        check("ovf_idle", 32'(state), 32'(0));
        @(negedge clk);

        // Start coincident with the first beat of a new load: load wins.
        eval_start = 1'b1;
        load_beat(2'b01, 1'b0, 8'h01, 16'h0001, "coll");
        eval_start = 1'b0;
        #1;
        check("coll_ovf_clr", 32'(ovf), 32'(0));
        check("coll_state", 32'(state), 32'(1));
        dcnt = 0;
        for (int c = 0; c < 3; c++) begin
            if (done) dcnt++;
            @(negedge clk);
            #1;
        end
        check("coll_no_done", 32'(dcnt), 32'(0));
        @(negedge clk);
        load_beat(2'b10, 1'b1, 8'hFE, 16'h0008, "coll_end");

        // Reset mid-LOAD.
        load_beat(2'b01, 1'b0, 8'h01, 16'h0001, "rl0");
        load_valid = 1'b1;
        load_lit   = 2'b10;
        #1;
        check("rl_wr_pre", 32'(wr), 32'(8'h02));
        rst = 1'b0;
        #1;
        check("rl_ready", 32'(load_ready), 32'(0));
        check("rl_wr", 32'(wr), 32'(0));
        check("rl_state", 32'(state), 32'(0));
        @(negedge clk);
        load_valid = 1'b0;
        load_lit   = 2'b00;
        rst        = 1'b1;
        @(negedge clk);
        load_beat(2'b10, 1'b1, 8'hFF, 16'h0002, "rl_fresh");

        // Reset mid-CDRV.
        do_eval(8'h00, 2'b00, 8'h00, 2'b11, 1, "rc");
        #1;
        check("rc_cdrv_pre", 32'(cclause_drv), 32'(1));
        rst = 1'b0;
        #1;
        check("rc_cdrv", 32'(cclause_drv), 32'(0));
        check("rc_result", 32'(result), 32'(0));
        check("rc_done", 32'(done), 32'(0));
        check("rc_state", 32'(state), 32'(0));
        check("rc_ready", 32'(load_ready), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        load_beat(2'b01, 1'b0, 8'h01, 16'h0001, "rc_fresh0");
        load_beat(2'b10, 1'b1, 8'hFE, 16'h0008, "rc_fresh1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
